// File: rtl/sha3_stream_arbiter_if.sv
// rtl/sha3_stream_arbiter_if.sv - requester, core and digest stream bundle for sha3_stream_arbiter
interface sha3_stream_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            s_tvalid;
  logic [NUM_REQ-1:0]            s_tready;
  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata;
  logic [NUM_REQ-1:0]            s_tlast;
  logic [NUM_REQ*2-1:0]          s_tuser;
  logic                          m_tvalid;
  logic                          m_tready;
  logic [DATA_WIDTH-1:0]         m_tdata;
  logic                          m_tlast;
  logic [1:0]                    m_tuser;
  logic                          d_tvalid;
  logic                          d_tlast;
  logic [IDX_W-1:0]              o_tdest;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
  logic                          timeout_err;

  // Arbiter side
  modport slave (
    input  s_tvalid, s_tdata, s_tlast, s_tuser, m_tready, d_tvalid, d_tlast,
    output s_tready, m_tvalid, m_tdata, m_tlast, m_tuser, o_tdest, grant, busy, timeout_err
  );

  // Requesters / core / observer side
  modport master (
    output s_tvalid, s_tdata, s_tlast, s_tuser, m_tready, d_tvalid, d_tlast,
    input  s_tready, m_tvalid, m_tdata, m_tlast, m_tuser, o_tdest, grant, busy, timeout_err
  );
endinterface

// File: rtl/sha3_stream_arbiter.sv
// rtl/sha3_stream_arbiter.sv - round-robin message arbiter for a shared SHA3 core; optional digest watchdog via SHA_ARB_WATCHDOG_EN
module sha3_stream_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int IDX_W          = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                    ACLK,
  input logic                    ARESET,
  sha3_stream_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_DIGEST} state_t;

  state_t           state;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] tdest_q;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] next_ptr;
  logic             pick_found;
  logic             digest_done;
  logic             expire;
  int               cand;

  assign digest_done = bus.d_tvalid && bus.d_tlast;

  // First valid requester at or after rr_ptr, wrapping around
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    cand       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(rr_ptr) + i) % NUM_REQ;
      if (!pick_found && bus.s_tvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  // Pointer one past the current owner, modulo NUM_REQ
  always_comb begin
    if (int'(grant_idx) == NUM_REQ - 1) next_ptr = '0;
    else                                next_ptr = grant_idx + IDX_W'(1);
  end

`ifdef SHA_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  // Counts cycles spent in WAIT_DIGEST; zero everywhere else
  always_ff @(posedge ACLK) begin
    if (ARESET || state != WAIT_DIGEST) wd_cnt <= '0;
    else                                wd_cnt <= wd_cnt + WD_W'(1);
  end

  // A real digest on the expiry cycle wins over the timeout
  assign expire = (state == WAIT_DIGEST) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) && !digest_done;
`else
  assign expire = 1'b0;
`endif

  assign bus.timeout_err = expire;

  // Arbitration FSM: owner held from first beat until its digest completes
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
      tdest_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_idx <= pick_idx;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (bus.m_tvalid && bus.m_tready && bus.m_tlast) begin
            state   <= WAIT_DIGEST;
            tdest_q <= grant_idx;
          end
        end
        WAIT_DIGEST: begin
          if (digest_done || expire) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stream mux toward the core and ready fan-back to the owner only
  always_comb begin
    bus.m_tvalid = 1'b0;
    bus.m_tdata  = '0;
    bus.m_tlast  = 1'b0;
    bus.m_tuser  = '0;
    bus.s_tready = '0;
    bus.grant    = '0;
    if (state == STREAM) begin
      bus.m_tvalid            = bus.s_tvalid[grant_idx];
      bus.m_tdata             = bus.s_tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      bus.m_tlast             = bus.s_tlast[grant_idx];
      bus.m_tuser             = bus.s_tuser[grant_idx*2 +: 2];
      bus.s_tready[grant_idx] = bus.m_tready;
    end
    if (state != IDLE) bus.grant[grant_idx] = 1'b1;
  end

  assign bus.busy    = (state != IDLE);
  assign bus.o_tdest = tdest_q;

endmodule

// File: tb/tb_sha3_stream_arbiter.sv
// tb/tb_sha3_stream_arbiter.sv - directed self-checking bench for sha3_stream_arbiter
module tb_sha3_stream_arbiter;
  logic ACLK = 1'b0;
  logic ARESET;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_order [5] = '{0, 1, 2, 3, 0};

  sha3_stream_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(16), .IDX_W(2)) bus ();

  sha3_stream_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(16), .IDX_W(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .bus(bus)
  );

  always #5 ACLK = ~ACLK;

  task automatic cyc();
    @(posedge ACLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    ARESET       = 1'b1;
    bus.s_tvalid = '0;
    bus.s_tdata  = '0;
    bus.s_tlast  = '0;
    bus.s_tuser  = 8'b11_10_01_00;
    bus.m_tready = 1'b0;
    bus.d_tvalid = 1'b0;
    bus.d_tlast  = 1'b0;
    cyc();
    cyc();
    #1;
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_s_tready", 32'(bus.s_tready), 0);
    chk("rst_m_tvalid", 32'(bus.m_tvalid), 0);
    chk("rst_m_tdata", 32'(bus.m_tdata), 0);
    chk("rst_m_tlast", 32'(bus.m_tlast), 0);
    chk("rst_o_tdest", 32'(bus.o_tdest), 0);
    chk("rst_timeout", 32'(bus.timeout_err), 0);
    ARESET = 1'b0;

    // Three-beat message from requester 0
    bus.m_tready = 1'b1;
    bus.s_tvalid = 4'b0001;
    bus.s_tdata[15:0] = 16'h1111;
    #1;
    chk("idle_no_ready", 32'(bus.s_tready), 0);
    chk("idle_no_grant", 32'(bus.grant), 0);
    cyc(); #1;
    chk("t1_grant", 32'(bus.grant), 32'h1);
    chk("t1_busy", 32'(bus.busy), 1);
    chk("t1_beat0", 32'(bus.m_tdata), 32'h1111);
    chk("t1_tuser", 32'(bus.m_tuser), 0);
    chk("t1_ready", 32'(bus.s_tready), 32'h1);
    chk("t1_notlast0", 32'(bus.m_tlast), 0);
    cyc();
    bus.s_tdata[15:0] = 16'h2222;
    #1;
    chk("t1_beat1", 32'(bus.m_tdata), 32'h2222);
    cyc();
    bus.s_tdata[15:0] = 16'h3333;
    bus.s_tlast = 4'b0001;
    #1;
    chk("t1_beat2", 32'(bus.m_tdata), 32'h3333);
    chk("t1_last", 32'(bus.m_tlast), 1);
    cyc();
    bus.s_tvalid = '0;
    bus.s_tlast  = '0;
    #1;
    chk("t1_wait_mvalid", 32'(bus.m_tvalid), 0);
    chk("t1_wait_ready", 32'(bus.s_tready), 0);
    chk("t1_wait_busy", 32'(bus.busy), 1);
    chk("t1_wait_tdest", 32'(bus.o_tdest), 0);
    bus.d_tvalid = 1'b1;
    cyc(); #1;
    chk("t1_nonlast_digest", 32'(bus.busy), 1);
    bus.d_tlast = 1'b1;
    cyc();
    bus.d_tvalid = 1'b0;
    bus.d_tlast  = 1'b0;
    #1;
    chk("t1_done_busy", 32'(bus.busy), 0);
    chk("t1_done_grant", 32'(bus.grant), 0);

    // Round robin over four continuous single-beat requesters
    ARESET = 1'b1;
    cyc();
    ARESET = 1'b0;
    bus.s_tlast  = 4'b1111;
    bus.s_tdata  = {16'hA303, 16'hA202, 16'hA101, 16'hA000};
    bus.s_tvalid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cyc(); #1;
      chk("rr_grant", 32'(bus.grant), 32'(1) << exp_order[k]);
      chk("rr_data", 32'(bus.m_tdata), 32'h0000A000 + 32'(exp_order[k]) * 32'h0101);
      cyc(); #1;
      chk("rr_tdest", 32'(bus.o_tdest), 32'(exp_order[k]));
      repeat (4) cyc();
      bus.d_tvalid = 1'b1;
      bus.d_tlast  = 1'b1;
      #1;
      chk("rr_tdest_digest", 32'(bus.o_tdest), 32'(exp_order[k]));
      cyc();
      bus.d_tvalid = 1'b0;
      bus.d_tlast  = 1'b0;
      #1;
      chk("rr_idle", 32'(bus.busy), 0);
    end

    // Owner 2 stalls mid-message while requester 1 waits
    bus.s_tvalid = 4'b0100;
    bus.s_tlast  = '0;
    bus.s_tdata[47:32] = 16'h3030;
    cyc(); #1;
    chk("st_grant", 32'(bus.grant), 32'h4);
    bus.s_tvalid = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      cyc(); #1;
      chk("st_hold_grant", 32'(bus.grant), 32'h4);
      chk("st_hold_ready", 32'(bus.s_tready), 32'h4);
    end
    bus.s_tvalid = 4'b0110;
    bus.s_tdata[47:32] = 16'h4444;
    bus.m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_data", 32'(bus.m_tdata), 32'h4444);
      chk("bp_ready", 32'(bus.s_tready), 0);
      cyc();
    end
    bus.m_tready = 1'b1;
    #1;
    chk("bp_release", 32'(bus.s_tready), 32'h4);
    cyc();
    bus.s_tdata[47:32] = 16'h5555;
    bus.s_tlast = 4'b0100;
    #1;
    chk("st_last_data", 32'(bus.m_tdata), 32'h5555);
    chk("st_last_tuser", 32'(bus.m_tuser), 32'h2);
    cyc();
    bus.s_tlast = '0;
    #1;
    chk("st_wait_tdest", 32'(bus.o_tdest), 2);
    chk("st_wait_ready", 32'(bus.s_tready), 0);
    bus.d_tvalid = 1'b1;
    bus.d_tlast  = 1'b1;
    cyc();
    bus.d_tvalid = 1'b0;
    bus.d_tlast  = 1'b0;
    #1;
    chk("st_idle", 32'(bus.busy), 0);
    cyc(); #1;
    chk("st_next_owner", 32'(bus.grant), 32'h2);

    // Reset in the middle of STREAM
    ARESET = 1'b1;
    cyc();
    ARESET = 1'b0;
    bus.s_tvalid = 4'b1001;
    bus.s_tlast  = 4'b0001;
    bus.s_tdata[15:0] = 16'h0B0B;
    #1;
    chk("mr_grant", 32'(bus.grant), 0);
    chk("mr_busy", 32'(bus.busy), 0);
    chk("mr_ready", 32'(bus.s_tready), 0);
    chk("mr_mvalid", 32'(bus.m_tvalid), 0);
    cyc(); #1;
    chk("mr_ptr_zero", 32'(bus.grant), 32'h1);
    chk("mr_data", 32'(bus.m_tdata), 32'h0B0B);
    cyc();
    bus.s_tvalid = 4'b1000;
    bus.s_tlast  = '0;

`ifdef SHA_ARB_WATCHDOG_EN
    for (int i = 0; i < 15; i++) begin
      #1;
      chk("wd_quiet", 32'(bus.timeout_err), 0);
      cyc();
    end
    #1;
    chk("wd_pulse", 32'(bus.timeout_err), 1);
    chk("wd_pulse_busy", 32'(bus.busy), 1);
    cyc(); #1;
    chk("wd_after", 32'(bus.timeout_err), 0);
    chk("wd_idle", 32'(bus.busy), 0);
    cyc(); #1;
    chk("wd_next_grant", 32'(bus.grant), 32'h8);
`else
    for (int i = 0; i < 20; i++) begin
      cyc(); #1;
      chk("nowd_busy", 32'(bus.busy), 1);
      chk("nowd_timeout", 32'(bus.timeout_err), 0);
    end
    bus.d_tvalid = 1'b1;
    bus.d_tlast  = 1'b1;
    cyc();
    bus.d_tvalid = 1'b0;
    bus.d_tlast  = 1'b0;
    cyc(); #1;
    chk("nowd_next_grant", 32'(bus.grant), 32'h8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
